// File: rtl/tc0360pri_pkg.sv
// Shared types and constants for the TC0360PRI priority register scheduler.
package tc0360pri_pkg;
    localparam int NREGS = 16;
    localparam int REG_W = 8;
    localparam int IDX_W = 4;

    typedef logic [NREGS-1:0][REG_W-1:0] pri_regs_t;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DONE
    } commit_state_t;

    localparam logic [IDX_W-1:0] REG_BLEND    = 4'd0;
    localparam logic [IDX_W-1:0] REG_FIX2     = 4'd1;
    localparam logic [IDX_W-1:0] REG_PRIO0_LO = 4'd4;
    localparam logic [IDX_W-1:0] REG_PRIO0_HI = 4'd5;
    localparam logic [IDX_W-1:0] REG_PRIO1_LO = 4'd6;
    localparam logic [IDX_W-1:0] REG_PRIO1_HI = 4'd7;
    localparam logic [IDX_W-1:0] REG_PRIO2_LO = 4'd8;
    localparam logic [IDX_W-1:0] REG_PRIO2_HI = 4'd9;
    localparam logic [IDX_W-1:0] LAST_IDX     = 4'(NREGS - 1);
endpackage

// File: rtl/tc0360pri_regbank.sv
// Shadow/active register banks with dirty flags.
// Active-bank write priority: save-state write > forwarded CPU write > commit copy.
module tc0360pri_regbank
    import tc0360pri_pkg::*;
#(
    parameter bit SYNC_COMMIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_we_i,
    input  logic [IDX_W-1:0]         cpu_addr_i,
    input  logic [REG_W-1:0]         cpu_din_i,
    input  logic                     copy_en_i,
    input  logic [IDX_W-1:0]         copy_idx_i,
    input  logic                     ss_we_shadow_i,
    input  logic                     ss_we_active_i,
    input  logic [IDX_W-1:0]         ss_idx_i,
    input  logic [REG_W-1:0]         ss_wdata_i,
    output logic [NREGS*REG_W-1:0]   shadow_o,
    output logic [NREGS*REG_W-1:0]   active_o,
    output logic [NREGS-1:0]         dirty_o
);
    pri_regs_t        shadow_q, shadow_d;
    pri_regs_t        active_q, active_d;
    logic [NREGS-1:0] dirty_q, dirty_d;
    logic             fwd_hit;

    // A CPU write landing on the index being scanned is forwarded, so it never stays dirty.
    assign fwd_hit = copy_en_i && (cpu_addr_i == copy_idx_i);

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        if (copy_en_i) begin
            if (dirty_q[copy_idx_i]) begin
                active_d[copy_idx_i] = shadow_q[copy_idx_i];
            end
            dirty_d[copy_idx_i] = 1'b0;
        end
        if (cpu_we_i) begin
            shadow_d[cpu_addr_i] = cpu_din_i;
            if (!SYNC_COMMIT || fwd_hit) begin
                active_d[cpu_addr_i] = cpu_din_i;
            end else begin
                dirty_d[cpu_addr_i] = 1'b1;
            end
        end
        if (ss_we_shadow_i) begin
            shadow_d[ss_idx_i] = ss_wdata_i;
        end
        if (ss_we_active_i) begin
            active_d[ss_idx_i] = ss_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
            dirty_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
        end
    end

    assign shadow_o = shadow_q;
    assign active_o = active_q;
    assign dirty_o  = dirty_q;
endmodule

// File: rtl/tc0360pri_regsched.sv
// TC0360PRI register scheduler: CPU/save-state arbitration and vblank-synchronous commit engine.
// CPU always wins the register file; save-state access waits for an idle CPU cycle.
module tc0360pri_regsched #(
    parameter bit SYNC_COMMIT = 1'b1,
    parameter int NREGS       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_cs,
    input  logic                 cpu_rw,
    input  logic                 cpu_ds_n,
    input  logic [3:0]           cpu_addr,
    input  logic [7:0]           cpu_din,
    output logic [7:0]           cpu_dout,
    output logic                 cpu_dtack,
    input  logic                 vblank,
    input  logic                 ss_req,
    input  logic                 ss_we,
    input  logic [4:0]           ss_addr,
    input  logic [7:0]           ss_wdata,
    output logic [7:0]           ss_rdata,
    output logic                 ss_ack,
    output logic [NREGS*8-1:0]   active_regs,
    output logic                 commit_busy,
    output logic [NREGS-1:0]     dirty
);
    import tc0360pri_pkg::*;

    commit_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             vblank_q, vblank_rise;
    logic [REG_W-1:0] cpu_dout_q, ss_rdata_q;
    logic             cpu_dtack_q, ss_ack_q;
    logic             cpu_we, ss_grant;
    pri_regs_t        shadow_v, active_v;

    assign cpu_we      = cpu_cs && !cpu_rw && !cpu_ds_n;
    // ss_ack_q blocks re-service while the requester is still dropping its level request.
    assign ss_grant    = ss_req && !cpu_cs && !ss_ack_q;
    assign vblank_rise = vblank && !vblank_q;

    tc0360pri_regbank #(
        .SYNC_COMMIT(SYNC_COMMIT)
    ) u_bank (
        .clk            (clk),
        .reset          (reset),
        .cpu_we_i       (cpu_we),
        .cpu_addr_i     (cpu_addr),
        .cpu_din_i      (cpu_din),
        .copy_en_i      (state_q == COPY),
        .copy_idx_i     (idx_q),
        .ss_we_shadow_i (ss_grant && ss_we && !ss_addr[4]),
        .ss_we_active_i (ss_grant && ss_we && ss_addr[4]),
        .ss_idx_i       (ss_addr[3:0]),
        .ss_wdata_i     (ss_wdata),
        .shadow_o       (shadow_v),
        .active_o       (active_v),
        .dirty_o        (dirty)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (vblank_rise && SYNC_COMMIT) begin
                    state_d = COPY;
                    idx_d   = '0;
                end
            end
            COPY: begin
                if (vblank_rise) begin
                    pend_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE: begin
                if (pend_q || vblank_rise) begin
                    state_d = COPY;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vblank_q    <= 1'b0;
            cpu_dout_q  <= '0;
            cpu_dtack_q <= 1'b0;
            ss_rdata_q  <= '0;
            ss_ack_q    <= 1'b0;
        end else begin
            vblank_q    <= vblank;
            cpu_dtack_q <= cpu_cs;
            ss_ack_q    <= ss_grant;
            if (cpu_cs && cpu_rw) begin
                cpu_dout_q <= shadow_v[cpu_addr];
            end
            if (ss_grant) begin
                ss_rdata_q <= ss_addr[4] ? active_v[ss_addr[3:0]] : shadow_v[ss_addr[3:0]];
            end
        end
    end

    assign cpu_dout    = cpu_dout_q;
    assign cpu_dtack   = cpu_dtack_q;
    assign ss_rdata    = ss_rdata_q;
    assign ss_ack      = ss_ack_q;
    assign active_regs = active_v;
    assign commit_busy = (state_q == COPY);
endmodule

// File: tb/tb_tc0360pri_regsched.sv
// Bench for tc0360pri_regsched: one vblank-commit instance and one immediate-write instance
// driven with the same stimulus and compared every cycle against a register-file model.
module tb_tc0360pri_regsched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, cpu_cs, cpu_rw, cpu_ds_n, vblank, ss_req, ss_we;
    logic [3:0]   cpu_addr;
    logic [7:0]   cpu_din, ss_wdata;
    logic [4:0]   ss_addr;

    logic [7:0]   cpu_dout, ss_rdata, cpu_dout0, ss_rdata0;
    logic         cpu_dtack, ss_ack, commit_busy, cpu_dtack0, ss_ack0, commit_busy0;
    logic [127:0] active_regs, active_regs0;
    logic [15:0]  dirty, dirty0;

    tc0360pri_regsched #(.SYNC_COMMIT(1'b1), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_ds_n(cpu_ds_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_dtack(cpu_dtack),
        .vblank(vblank), .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
        .ss_rdata(ss_rdata), .ss_ack(ss_ack), .active_regs(active_regs),
        .commit_busy(commit_busy), .dirty(dirty)
    );

    tc0360pri_regsched #(.SYNC_COMMIT(1'b0), .NREGS(16)) dut0 (
        .clk(clk), .reset(reset), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_ds_n(cpu_ds_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout0), .cpu_dtack(cpu_dtack0),
        .vblank(vblank), .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
        .ss_rdata(ss_rdata0), .ss_ack(ss_ack0), .active_regs(active_regs0),
        .commit_busy(commit_busy0), .dirty(dirty0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: bank contents as byte arrays, commit pass as a position counter
    // (-1 idle, 0..15 scanning that register, 16 the gap cycle after a pass).
    logic [7:0] m_sh[16], m_act[16], m_act0[16];
    logic       m_dirt[16];
    logic [7:0] m_dout, m_rd, m_rd0;
    logic       m_dtack, m_ack, m_vb, m_pend;
    int         m_pos;

    function automatic logic [127:0] pack(input logic [7:0] a[16]);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = a[i];
        return r;
    endfunction

    function automatic logic [15:0] pack_dirty();
        logic [15:0] r = '0;
        for (int i = 0; i < 16; i++) r[i] = m_dirt[i];
        return r;
    endfunction

    task automatic model_step();
        logic [7:0] sh_n[16], act_n[16], act0_n[16];
        logic       dirt_n[16];
        logic       rise, grant, wr, copying;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_sh[i] = 8'h00; m_act[i] = 8'h00; m_act0[i] = 8'h00; m_dirt[i] = 1'b0;
            end
            m_dout = 8'h00; m_rd = 8'h00; m_rd0 = 8'h00;
            m_dtack = 1'b0; m_ack = 1'b0; m_vb = 1'b0; m_pend = 1'b0; m_pos = -1;
            return;
        end
        rise    = vblank && !m_vb;
        m_vb    = vblank;
        grant   = ss_req && !cpu_cs && !m_ack;
        wr      = cpu_cs && !cpu_rw && !cpu_ds_n;
        copying = (m_pos >= 0) && (m_pos < 16);
        sh_n = m_sh; act_n = m_act; act0_n = m_act0; dirt_n = m_dirt;

        if (grant) begin
            m_rd  = ss_addr[4] ? m_act[ss_addr[3:0]]  : m_sh[ss_addr[3:0]];
            m_rd0 = ss_addr[4] ? m_act0[ss_addr[3:0]] : m_sh[ss_addr[3:0]];
        end
        if (cpu_cs && cpu_rw) m_dout = m_sh[cpu_addr];
        m_dtack = cpu_cs;
        m_ack   = grant;

        if (copying) begin
            if (m_dirt[m_pos]) act_n[m_pos] = m_sh[m_pos];
            dirt_n[m_pos] = 1'b0;
        end
        if (wr) begin
            sh_n[cpu_addr]   = cpu_din;
            act0_n[cpu_addr] = cpu_din;
            if (copying && (int'(cpu_addr) == m_pos)) act_n[cpu_addr] = cpu_din;
            else dirt_n[cpu_addr] = 1'b1;
        end
        if (grant && ss_we) begin
            if (ss_addr[4]) begin
                act_n[ss_addr[3:0]]  = ss_wdata;
                act0_n[ss_addr[3:0]] = ss_wdata;
            end else begin
                sh_n[ss_addr[3:0]] = ss_wdata;
            end
        end
        m_sh = sh_n; m_act = act_n; m_act0 = act0_n; m_dirt = dirt_n;

        if (m_pos < 0) begin
            if (rise) m_pos = 0;
        end else if (m_pos < 16) begin
            if (rise) m_pend = 1'b1;
            m_pos++;
        end else if (m_pend || rise) begin
            m_pos  = 0;
            m_pend = 1'b0;
        end else begin
            m_pos = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("active", active_regs, pack(m_act));
        check("dirty", dirty, pack_dirty());
        check("busy", commit_busy, (m_pos >= 0 && m_pos < 16));
        check("dout", cpu_dout, m_dout);
        check("dtack", cpu_dtack, m_dtack);
        check("ss_ack", ss_ack, m_ack);
        check("ss_rdata", ss_rdata, m_rd);
        check("active0", active_regs0, pack(m_act0));
        check("dirty0", dirty0, 16'h0);
        check("busy0", commit_busy0, 1'b0);
        check("ss_rdata0", ss_rdata0, m_rd0);
        check("dout0", cpu_dout0, m_dout);
    endtask

    task automatic cpu_idle();
        cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_ds_n = 1'b1;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_ds_n = 1'b0; cpu_addr = a; cpu_din = d;
    endtask

    int busy_cnt;

    initial begin
        reset = 1'b1; vblank = 1'b0; ss_req = 1'b0; ss_we = 1'b0;
        ss_addr = '0; ss_wdata = '0; cpu_addr = '0; cpu_din = '0;
        cpu_idle();
        tick(); tick();
        check("rst_active", active_regs, 128'h0);
        check("rst_busy", commit_busy, 1'b0);
        check("rst_dtack", cpu_dtack, 1'b0);
        reset = 1'b0;
        tick();

        // Write without vblank stays in the shadow bank.
        cpu_write(4'd4, 8'h21);
        tick();
        cpu_idle();
        check("w4_active", active_regs[39:32], 8'h00);
        check("w4_dirty", dirty, 16'h0010);
        cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 4'd4;
        tick();
        check("r4_dout", cpu_dout, 8'h21);
        check("r4_dtack", cpu_dtack, 1'b1);
        cpu_idle();
        tick();

        // Commit pass with writes at and behind the scan position.
        vblank = 1'b1;
        tick();
        check("pass_busy0", commit_busy, 1'b1);
        repeat (7) tick();
        cpu_write(4'd7, 8'hAA);
        tick();
        cpu_write(4'd2, 8'h55);
        tick();
        cpu_idle();
        repeat (6) tick();
        check("pass_busy15", commit_busy, 1'b1);
        tick();
        check("pass_done", commit_busy, 1'b0);
        check("pass_act7", active_regs[63:56], 8'hAA);
        check("pass_act4", active_regs[39:32], 8'h21);
        check("pass_act2", active_regs[23:16], 8'h00);
        check("pass_dirty", dirty, 16'h0004);
        tick();

        // Save-state read of active reg 4 held off by CPU traffic.
        cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 4'd0;
        ss_req = 1'b1; ss_we = 1'b0; ss_addr = 5'h14;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ss_hold", ss_ack, 1'b0);
        end
        cpu_idle();
        tick();
        check("ss_ack", ss_ack, 1'b1);
        check("ss_rd4", ss_rdata, 8'h21);
        ss_req = 1'b0;
        tick();
        check("ss_ack_drop", ss_ack, 1'b0);

        // Two extra vblank rises inside one pass queue exactly one more pass.
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (commit_busy) busy_cnt++;
            vblank = (i == 1 || i == 3) ? 1'b0 : 1'b1;
            tick();
        end
        check("two_pass_cycles", busy_cnt, 32);

        // Reset in the middle of a pass.
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        repeat (9) tick();
        reset = 1'b1; vblank = 1'b0;
        tick();
        check("midrst_active", active_regs, 128'h0);
        check("midrst_busy", commit_busy, 1'b0);
        reset = 1'b0;
        tick();

        // Immediate-write instance.
        cpu_write(4'd0, 8'hC3);
        tick();
        cpu_idle();
        check("imm_act0", active_regs0[7:0], 8'hC3);
        check("sync_act0", active_regs[7:0], 8'h00);
        vblank = 1'b1;
        repeat (4) tick();
        check("imm_nobusy", commit_busy0, 1'b0);

        // Randomised traffic.
        for (int c = 0; c < 2500; c++) begin
            cpu_cs   = ($urandom % 3) == 0;
            cpu_rw   = $urandom % 2;
            cpu_ds_n = ($urandom % 4) == 0;
            cpu_addr = 4'($urandom);
            cpu_din  = 8'($urandom);
            if (ss_req && ss_ack) begin
                ss_req = 1'b0;
            end else if (!ss_req && ($urandom % 5) == 0) begin
                ss_req   = 1'b1;
                ss_we    = $urandom % 2;
                ss_addr  = 5'($urandom);
                ss_wdata = 8'($urandom);
            end
            if (($urandom % 12) == 0) vblank = ~vblank;
            reset = ($urandom % 600) == 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
